// File: rtl/cpu_seq_if.sv
// ============================================================================
// Module      : cpu_seq_if
// Description : Control/status bundle between the 4-bit CPU sequencer and its
//               ROM/PC/ALU/register datapath.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface cpu_seq_if;
    logic       run;
    logic [7:0] instr;
    logic       alu_z;
    logic       alu_c;
    logic       pc_clr;
    logic       pc_inc;
    logic       pc_load;
    logic [3:0] imm;
    logic       a_load;
    logic       a_src;
    logic       b_load;
    logic [1:0] alu_op;
    logic       out_load;
    logic       halted;
    logic       illegal;

    // Sequencer side
    modport master (
        input  run, instr, alu_z, alu_c,
        output pc_clr, pc_inc, pc_load, imm, a_load, a_src, b_load,
               alu_op, out_load, halted, illegal
    );

    // Datapath side
    modport slave (
        output run, instr, alu_z, alu_c,
        input  pc_clr, pc_inc, pc_load, imm, a_load, a_src, b_load,
               alu_op, out_load, halted, illegal
    );
endinterface

`default_nettype wire

// File: rtl/cpu_seq.sv
// ============================================================================
// Module      : cpu_seq
// Description : Multi-cycle FETCH/DECODE/EXEC/UPDATE sequencer holding IR and
//               Z/C flags; drives PC, register-load and ALU control strobes.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module cpu_seq (
    input  logic       clk,
    input  logic       rst_n,
    cpu_seq_if.master  bus_if
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_UPDATE = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [3:0] c_OP_LDA = 4'h1;
    localparam logic [3:0] c_OP_LDB = 4'h2;
    localparam logic [3:0] c_OP_ADD = 4'h3;
    localparam logic [3:0] c_OP_SUB = 4'h4;
    localparam logic [3:0] c_OP_AND = 4'h5;
    localparam logic [3:0] c_OP_OR  = 4'h6;
    localparam logic [3:0] c_OP_OUT = 4'h7;
    localparam logic [3:0] c_OP_JMP = 4'h8;
    localparam logic [3:0] c_OP_JZ  = 4'h9;
    localparam logic [3:0] c_OP_JC  = 4'hA;
    localparam logic [3:0] c_OP_HLT = 4'hF;

    state_e     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic       z_q, z_d;
    logic       c_q, c_d;

    logic       pc_clr_q,   pc_clr_d;
    logic       pc_inc_q,   pc_inc_d;
    logic       pc_load_q,  pc_load_d;
    logic       a_load_q,   a_load_d;
    logic       a_src_q,    a_src_d;
    logic       b_load_q,   b_load_d;
    logic [1:0] alu_op_q,   alu_op_d;
    logic       out_load_q, out_load_d;
    logic       halted_q,   halted_d;
    logic       illegal_q,  illegal_d;

    logic [3:0] op_q;
    logic [3:0] op_d;
    logic       is_alu_q;
    logic       taken_d;

    assign op_q     = ir_q[7:4];
    assign op_d     = ir_d[7:4];
    assign is_alu_q = (op_q >= c_OP_ADD) && (op_q <= c_OP_OR);

    // Next state, IR and flags
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        z_d     = z_q;
        c_d     = c_q;
        case (state_q)
            S_IDLE:   if (bus_if.run) state_d = S_FETCH;
            S_FETCH: begin
                ir_d    = bus_if.instr;
                state_d = S_DECODE;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                state_d = (op_q == c_OP_HLT) ? S_HALT : S_UPDATE;
                if (is_alu_q) begin
                    z_d = bus_if.alu_z;
                    c_d = ((op_q == c_OP_ADD) || (op_q == c_OP_SUB)) ? bus_if.alu_c : 1'b0;
                end
            end
            S_UPDATE: state_d = bus_if.run ? S_FETCH : S_IDLE;
            S_HALT:   if (!bus_if.run) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Strobes are decoded from the upcoming state so they register in step with it
    always_comb begin
        pc_clr_d   = (state_d == S_IDLE);
        halted_d   = (state_d == S_HALT);
        pc_inc_d   = 1'b0;
        pc_load_d  = 1'b0;
        a_load_d   = 1'b0;
        a_src_d    = 1'b0;
        b_load_d   = 1'b0;
        alu_op_d   = 2'b00;
        out_load_d = 1'b0;
        illegal_d  = 1'b0;
        taken_d    = (op_d == c_OP_JMP) ||
                     ((op_d == c_OP_JZ) && z_d) ||
                     ((op_d == c_OP_JC) && c_d);
        if (state_d == S_EXEC) begin
            case (op_d)
                c_OP_LDA: begin a_load_d = 1'b1; a_src_d = 1'b1; end
                c_OP_LDB: b_load_d = 1'b1;
                c_OP_ADD: begin a_load_d = 1'b1; alu_op_d = 2'b00; end
                c_OP_SUB: begin a_load_d = 1'b1; alu_op_d = 2'b01; end
                c_OP_AND: begin a_load_d = 1'b1; alu_op_d = 2'b10; end
                c_OP_OR:  begin a_load_d = 1'b1; alu_op_d = 2'b11; end
                c_OP_OUT: out_load_d = 1'b1;
                default:  illegal_d = (op_d >= 4'hB) && (op_d <= 4'hE);
            endcase
        end
        if (state_d == S_UPDATE) begin
            pc_load_d = taken_d;
            pc_inc_d  = !taken_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ir_q       <= 8'h00;
            z_q        <= 1'b0;
            c_q        <= 1'b0;
            pc_clr_q   <= 1'b1;
            pc_inc_q   <= 1'b0;
            pc_load_q  <= 1'b0;
            a_load_q   <= 1'b0;
            a_src_q    <= 1'b0;
            b_load_q   <= 1'b0;
            alu_op_q   <= 2'b00;
            out_load_q <= 1'b0;
            halted_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            z_q        <= z_d;
            c_q        <= c_d;
            pc_clr_q   <= pc_clr_d;
            pc_inc_q   <= pc_inc_d;
            pc_load_q  <= pc_load_d;
            a_load_q   <= a_load_d;
            a_src_q    <= a_src_d;
            b_load_q   <= b_load_d;
            alu_op_q   <= alu_op_d;
            out_load_q <= out_load_d;
            halted_q   <= halted_d;
            illegal_q  <= illegal_d;
        end
    end

    assign bus_if.pc_clr   = pc_clr_q;
    assign bus_if.pc_inc   = pc_inc_q;
    assign bus_if.pc_load  = pc_load_q;
    assign bus_if.imm      = ir_q[3:0];
    assign bus_if.a_load   = a_load_q;
    assign bus_if.a_src    = a_src_q;
    assign bus_if.b_load   = b_load_q;
    assign bus_if.alu_op   = alu_op_q;
    assign bus_if.out_load = out_load_q;
    assign bus_if.halted   = halted_q;
    assign bus_if.illegal  = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_seq.sv
// ============================================================================
// Module      : tb_cpu_seq
// Description : Directed self-checking bench for cpu_seq with a small ROM/PC
//               model standing in for the datapath.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_cpu_seq;

    logic       clk;
    logic       rst_n;
    logic [7:0] rom [16];
    logic [3:0] pc;
    int         n_cmp;
    int         n_err;

    cpu_seq_if bus();

    cpu_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stand-in: PC register addressing the instruction ROM
    always @(posedge clk) begin
        if (bus.pc_clr)       pc <= 4'h0;
        else if (bus.pc_load) pc <= bus.imm;
        else if (bus.pc_inc)  pc <= pc + 4'h1;
    end
    assign bus.instr = rom[pc];

    // {pc_clr,pc_inc,pc_load,a_load,a_src,b_load,alu_op[1:0],out_load,halted,illegal}
    function automatic logic [10:0] outs();
        return {bus.pc_clr, bus.pc_inc, bus.pc_load, bus.a_load, bus.a_src,
                bus.b_load, bus.alu_op, bus.out_load, bus.halted, bus.illegal};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_rom(input logic [7:0] fill);
        for (int i = 0; i < 16; i++) rom[i] = fill;
    endtask

    task automatic do_reset();
        bus.run   = 1'b0;
        bus.alu_z = 1'b0;
        bus.alu_c = 1'b0;
        rst_n     = 1'b0;
        tick();
        tick();
        rst_n     = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (outs() !== 11'h400) begin n_err++; $display("FAIL reset_idle: outs=%h exp=%h", outs(), 11'h400); end
        load_rom(8'h00);
        rom[0] = 8'h40; rom[1] = 8'h30;
        bus.alu_z = 1'b1; bus.alu_c = 1'b1; bus.run = 1'b1;
        for (int c = 1; c <= 7; c++) tick();
        n_cmp++; if (outs() !== 11'h080) begin n_err++; $display("FAIL reset_add_exec: outs=%h exp=%h", outs(), 11'h080); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (outs() !== 11'h400 || bus.imm !== 4'h0) begin n_err++; $display("FAIL reset_async: outs=%h imm=%h exp=400/0", outs(), bus.imm); end
        bus.alu_z = 1'b0; bus.alu_c = 1'b0;
        rom[0] = 8'h97; rom[1] = 8'hA7;
        tick();
        n_cmp++; if (outs() !== 11'h400) begin n_err++; $display("FAIL reset_held: outs=%h exp=%h", outs(), 11'h400); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (outs() !== 11'h000 || pc !== 4'h0) begin n_err++; $display("FAIL reset_first_fetch: outs=%h pc=%h exp=000/0", outs(), pc); end
        for (int c = 2; c <= 8; c++) begin
            tick();
            if (c == 4) begin n_cmp++; if (outs() !== 11'h200) begin n_err++; $display("FAIL reset_z_cleared: outs=%h exp=%h", outs(), 11'h200); end end
            if (c == 8) begin n_cmp++; if (outs() !== 11'h200) begin n_err++; $display("FAIL reset_c_cleared: outs=%h exp=%h", outs(), 11'h200); end end
        end
    endtask

    task automatic test_program();
        do_reset();
        load_rom(8'h00);
        rom[0] = 8'h15; rom[1] = 8'h23; rom[2] = 8'h30; rom[3] = 8'h70; rom[4] = 8'hF0;
        bus.run = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            case (c)
                3:  begin n_cmp++; if (outs() !== 11'h0C0 || bus.imm !== 4'h5) begin n_err++; $display("FAIL prog_lda: outs=%h imm=%h exp=0c0/5", outs(), bus.imm); end end
                7:  begin n_cmp++; if (outs() !== 11'h020 || bus.imm !== 4'h3) begin n_err++; $display("FAIL prog_ldb: outs=%h imm=%h exp=020/3", outs(), bus.imm); end end
                11: begin n_cmp++; if (outs() !== 11'h080) begin n_err++; $display("FAIL prog_add: outs=%h exp=%h", outs(), 11'h080); end end
                12: begin n_cmp++; if (outs() !== 11'h200) begin n_err++; $display("FAIL prog_add_update: outs=%h exp=%h", outs(), 11'h200); end end
                15: begin n_cmp++; if (outs() !== 11'h004) begin n_err++; $display("FAIL prog_out: outs=%h exp=%h", outs(), 11'h004); end end
                19: begin n_cmp++; if (outs() !== 11'h000) begin n_err++; $display("FAIL prog_hlt_exec: outs=%h exp=%h", outs(), 11'h000); end end
                20: begin n_cmp++; if (outs() !== 11'h002 || pc !== 4'h4) begin n_err++; $display("FAIL prog_halted: outs=%h pc=%h exp=002/4", outs(), pc); end end
                default: ;
            endcase
        end
    endtask

    task automatic test_cond_jump();
        for (int z = 1; z >= 0; z--) begin
            do_reset();
            load_rom(8'h00);
            rom[0] = 8'h40; rom[1] = 8'h9A;
            bus.alu_z = z[0]; bus.run = 1'b1;
            for (int c = 1; c <= 9; c++) begin
                tick();
                if (c == 3) begin n_cmp++; if (outs() !== 11'h088) begin n_err++; $display("FAIL jz_sub_exec: outs=%h exp=%h", outs(), 11'h088); end end
                if (c == 8 && z == 1) begin n_cmp++; if (outs() !== 11'h100 || bus.imm !== 4'hA) begin n_err++; $display("FAIL jz_taken: outs=%h imm=%h exp=100/a", outs(), bus.imm); end end
                if (c == 8 && z == 0) begin n_cmp++; if (outs() !== 11'h200) begin n_err++; $display("FAIL jz_not_taken: outs=%h exp=%h", outs(), 11'h200); end end
                if (c == 9) begin n_cmp++; if (pc !== (z == 1 ? 4'hA : 4'h2)) begin n_err++; $display("FAIL jz_pc: pc=%h exp=%h", pc, (z == 1 ? 4'hA : 4'h2)); end end
            end
        end
        do_reset();
        load_rom(8'h00);
        rom[0] = 8'h50; rom[1] = 8'hA5; rom[2] = 8'h30; rom[3] = 8'hA9;
        bus.alu_c = 1'b1; bus.run = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            tick();
            if (c == 3)  begin n_cmp++; if (outs() !== 11'h090) begin n_err++; $display("FAIL jc_and_exec: outs=%h exp=%h", outs(), 11'h090); end end
            if (c == 8)  begin n_cmp++; if (outs() !== 11'h200) begin n_err++; $display("FAIL jc_after_and: outs=%h exp=%h", outs(), 11'h200); end end
            if (c == 16) begin n_cmp++; if (outs() !== 11'h100 || bus.imm !== 4'h9) begin n_err++; $display("FAIL jc_after_add: outs=%h imm=%h exp=100/9", outs(), bus.imm); end end
            if (c == 17) begin n_cmp++; if (pc !== 4'h9) begin n_err++; $display("FAIL jc_pc: pc=%h exp=9", pc); end end
        end
    endtask

    task automatic test_run_drop();
        do_reset();
        load_rom(8'h00);
        bus.run = 1'b1;
        tick();
        tick();
        bus.run = 1'b0;
        tick();
        n_cmp++; if (outs() !== 11'h000) begin n_err++; $display("FAIL drop_exec: outs=%h exp=%h", outs(), 11'h000); end
        tick();
        n_cmp++; if (outs() !== 11'h200) begin n_err++; $display("FAIL drop_update: outs=%h exp=%h", outs(), 11'h200); end
        tick();
        n_cmp++; if (outs() !== 11'h400) begin n_err++; $display("FAIL drop_idle: outs=%h exp=%h", outs(), 11'h400); end
        tick();
        n_cmp++; if (outs() !== 11'h400) begin n_err++; $display("FAIL drop_idle_stay: outs=%h exp=%h", outs(), 11'h400); end
        bus.run = 1'b1;
        tick();
        n_cmp++; if (outs() !== 11'h000 || pc !== 4'h0) begin n_err++; $display("FAIL drop_restart: outs=%h pc=%h exp=000/0", outs(), pc); end
        tick(); tick();
        n_cmp++; if (outs() !== 11'h000) begin n_err++; $display("FAIL drop_restart_exec: outs=%h exp=%h", outs(), 11'h000); end
    endtask

    task automatic test_illegal_halt();
        int halt_bad;
        halt_bad = 0;
        do_reset();
        load_rom(8'h00);
        rom[0] = 8'hC0; rom[1] = 8'hF0;
        bus.run = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 2) begin n_cmp++; if (outs() !== 11'h000) begin n_err++; $display("FAIL ill_decode: outs=%h exp=%h", outs(), 11'h000); end end
            if (c == 3) begin n_cmp++; if (outs() !== 11'h001) begin n_err++; $display("FAIL ill_exec: outs=%h exp=%h", outs(), 11'h001); end end
            if (c == 4) begin n_cmp++; if (outs() !== 11'h200) begin n_err++; $display("FAIL ill_update: outs=%h exp=%h", outs(), 11'h200); end end
            if (c == 8) begin n_cmp++; if (outs() !== 11'h002) begin n_err++; $display("FAIL hlt_enter: outs=%h exp=%h", outs(), 11'h002); end end
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            if (outs() !== 11'h002) halt_bad++;
        end
        n_cmp++; if (halt_bad !== 0) begin n_err++; $display("FAIL hlt_hold: bad_cycles=%0d exp=0", halt_bad); end
        bus.run = 1'b0;
        tick();
        n_cmp++; if (outs() !== 11'h400) begin n_err++; $display("FAIL hlt_exit: outs=%h exp=%h", outs(), 11'h400); end
    endtask

    task automatic test_wrap();
        int incs;
        int others;
        incs = 0;
        others = 0;
        do_reset();
        load_rom(8'h00);
        bus.run = 1'b1;
        for (int c = 1; c <= 64; c++) begin
            tick();
            if (bus.pc_inc) incs++;
            if (bus.pc_load || bus.pc_clr) others++;
        end
        n_cmp++; if (incs !== 16) begin n_err++; $display("FAIL wrap_inc_count: got=%0d exp=16", incs); end
        n_cmp++; if (others !== 0) begin n_err++; $display("FAIL wrap_load_clr: got=%0d exp=0", others); end
        tick();
        n_cmp++; if (outs() !== 11'h000 || pc !== 4'h0) begin n_err++; $display("FAIL wrap_refetch: outs=%h pc=%h exp=000/0", outs(), pc); end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        bus.run   = 1'b0;
        bus.alu_z = 1'b0;
        bus.alu_c = 1'b0;
        load_rom(8'h00);
        test_reset();
        test_program();
        test_cond_jump();
        test_run_drop();
        test_illegal_halt();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/cpu_seq.md
# cpu_seq

Multi-cycle control sequencer for the 4-bit CPU. Holds the instruction register and Z/C flag registers, and steps each instruction through FETCH, DECODE, EXEC and UPDATE. It drives the PC (increment, load or clear strobes), the A/B register loads, the ALU operation select and the output-port load. It sits between the instruction ROM (addressed by the current PC) and the PC/ALU/register datapath.

## Interface
- No parameters; instruction word fixed at 8 bits (opcode [7:4], imm [3:0]).
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- run  input  1  level; 1 = execute, 0 = stop at next instruction boundary
- instr  input  8  ROM data at current PC, valid whenever sequencer is in FETCH
- alu_z  input  1  ALU result == 0, valid during EXEC
- alu_c  input  1  ALU carry-out / no-borrow, valid during EXEC
- pc_clr  output  1  PC := 0 at next edge
- pc_inc  output  1  PC := PC+1 (mod 16) at next edge
- pc_load  output  1  PC := imm at next edge
- imm  output  4  IR[3:0]
- a_load  output  1  A register load
- a_src  output  1  0 = ALU result, 1 = imm
- b_load  output  1  B := imm
- alu_op  output  2  00 ADD, 01 SUB, 10 AND, 11 OR
- out_load  output  1  output port := A
- halted  output  1  sequencer in HALT
- illegal  output  1  one-cycle pulse in EXEC for an undefined opcode

## Operation
- States: IDLE, FETCH, DECODE, EXEC, UPDATE, HALT. Encoding is free.
- IDLE: pc_clr=1 while in IDLE. When run=1, go to FETCH. Otherwise stay.
- FETCH: IR := instr. Next state DECODE.
- DECODE: no strobes. Next state EXEC.
- EXEC: one-cycle strobes decoded from IR[7:4]:
  - 0 NOP: none.
  - 1 LDA: a_load=1, a_src=1.
  - 2 LDB: b_load=1.
  - 3 ADD / 4 SUB / 5 AND / 6 OR: a_load=1, a_src=0, alu_op = 00/01/10/11. Z := alu_z. C := alu_c for ADD/SUB. C := 0 for AND/OR.
  - 7 OUT: out_load=1.
  - 8 JMP, 9 JZ, A JC: no EXEC strobes.
  - F HLT: next state HALT. No UPDATE, PC not advanced.
  - B–E: illegal=1, otherwise treated as NOP.
- UPDATE: exactly one of pc_inc or pc_load is 1.
  - pc_load=1 for JMP, for JZ when Z=1, and for JC when C=1.
  - pc_inc=1 otherwise.
  - Next state FETCH if run=1, else IDLE.
- HALT: halted=1, all strobes 0. Go to IDLE when run=0. Stay while run=1.
- run is sampled only in IDLE, UPDATE and HALT. Deasserting run mid-instruction lets the instruction complete.
- Flags are updated only by ALU opcodes in EXEC. JZ/JC test the flags from the most recent ALU op.
- When not in the state that owns it, every strobe is 0. alu_op is 00 outside ALU EXEC.

## Timing
- rst_n low, asynchronous: state := IDLE, IR := 0x00, Z := 0, C := 0.
  - Takes effect immediately, including mid-instruction. No partial strobes after assertion.
  - Resulting outputs: pc_clr=1, all other outputs 0.
- Release of rst_n is synchronous to clk. The first state change occurs on the first rising edge with rst_n=1.
- All outputs are decoded from the state register and IR only. There is no combinational path from run, instr, alu_z or alu_c to any output.
- Latency: 4 cycles per instruction (FETCH→UPDATE), a constant 4 cycles whether or not a jump is taken.
- Start: 1 cycle from IDLE to FETCH after run=1 is sampled.
- PC wrap: pc_inc at PC=15 gives 0, handled by the datapath. The sequencer needs no special case.
- pc_clr, pc_inc and pc_load are mutually exclusive in every cycle.

## Test plan
- Reset: pulse rst_n low mid-EXEC of ADD.
  - Outputs drop immediately to pc_clr=1 with all others 0; Z=C=0.
  - After release with run=1: IDLE→FETCH on the next edge.
- Load/add program LDA 5; LDB 3; ADD; OUT; HLT:
  - ADD EXEC shows a_load=1, a_src=0, alu_op=00.
  - OUT EXEC shows out_load=1.
  - halted=1 at cycle 1+4×4+3 after run (IDLE→FETCH cycle, four 4-cycle instructions, then FETCH/DECODE/EXEC of HLT).
- Conditional jumps:
  - SUB with alu_z=1, then JZ 0xA: UPDATE shows pc_load=1, imm=0xA.
  - Repeat with alu_z=0: pc_inc=1, pc_load=0.
  - JC after AND with alu_c=1: not taken, because AND clears C.
- run drop: deassert run during DECODE of NOP.
  - EXEC and UPDATE (pc_inc=1) still occur, then IDLE with pc_clr=1.
  - Reassert run: execution restarts at FETCH.
- Illegal/halt:
  - Opcode 0xC: illegal=1 for exactly one cycle, pc_inc=1 in UPDATE.
  - HLT with run held 1: stays in HALT for 20 cycles. run=0 → IDLE next edge.
- Wrap: 16 consecutive NOPs from PC=0.
  - pc_inc asserted 16 times; the 17th FETCH refetches address 0.
  - pc_load and pc_clr never asserted.
